// File: rtl/fifo_wr_ctl.sv
// Frame-buffer burst fetcher feeding a display FIFO in the write-clock domain.
// Optional overflow check: define FIFO_WR_OVERFLOW_CHK_EN.
module fifo_wr_ctl #(
    parameter int FIFO_ALMOSTFULL_DEPTH = 1000,
    parameter int BURST_LEN             = 16,
    parameter int FRAME_BEATS           = 76800,
    parameter int DATA_WIDTH            = 16,
    parameter int ADDR_WIDTH            = 32
) (
    input  logic                  rst_n,
    input  logic                  fifo_wr_clk,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_wr_data,
    input  logic                  fifo_full,
    input  logic [9:0]            fifo_wr_cnt,
    input  logic                  frame_start,
    input  logic [ADDR_WIDTH-1:0] frame_base_addr,
    output logic                  burst_req,
    output logic [ADDR_WIDTH-1:0] burst_addr,
    input  logic                  burst_ack,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_valid,
    output logic                  frame_done,
    output logic                  ovf_err
);

    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int FW = $clog2(FRAME_BEATS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_NEXT = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] BURST_BYTES =
        ADDR_WIDTH'(BURST_LEN * DATA_WIDTH / 8);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
    localparam logic [FW-1:0] BURST_F   = FW'(BURST_LEN);
    localparam logic [FW-1:0] FRAME_F   = FW'(FRAME_BEATS);
    localparam logic [10:0]   ROOM_LIM  = 11'(FIFO_ALMOSTFULL_DEPTH);

    logic [1:0]            r_state;
    logic                  r_armed;
    logic                  r_pending;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [BW-1:0]         r_beat_cnt;
    logic [FW-1:0]         r_frame_cnt;
    logic                  r_wr_en;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic                  r_frame_done;

    logic w_room;
    logic w_beat;
    logic w_last;
    logic w_frame_end;

    // 11-bit sum so a near-full FIFO can never wrap into a false "room"
    assign w_room      = ({1'b0, fifo_wr_cnt} + 11'(BURST_LEN)) <= ROOM_LIM;
    assign w_beat      = (r_state == S_DATA) && rd_valid;
    assign w_last      = w_beat && (r_beat_cnt == LAST_BEAT);
    assign w_frame_end = (r_frame_cnt + BURST_F) == FRAME_F;

    always_ff @(posedge fifo_wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_armed      <= 1'b0;
            r_pending    <= 1'b0;
            r_base       <= '0;
            r_addr       <= '0;
            r_beat_cnt   <= '0;
            r_frame_cnt  <= '0;
            r_wr_en      <= 1'b0;
            r_wr_data    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_wr_en <= w_beat;
            if (w_beat) begin
                r_wr_data <= rd_data;
            end
            // a restart arriving now or earlier in the burst cancels the frame end
            r_frame_done <= w_last && w_frame_end && !r_pending && !frame_start;
            if (frame_start) begin
                r_armed <= 1'b1;
                r_base  <= frame_base_addr;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (frame_start) begin
                        r_addr      <= frame_base_addr;
                        r_frame_cnt <= '0;
                    end
                    if (r_armed && w_room) begin
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (frame_start) begin
                        r_pending <= 1'b1;
                    end
                    if (burst_ack) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (frame_start) begin
                        r_pending <= 1'b1;
                    end
                    if (w_beat) begin
                        r_beat_cnt <= w_last ? '0 : r_beat_cnt + 1'b1;
                    end
                    if (w_last) begin
                        r_state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    r_state   <= S_IDLE;
                    r_pending <= 1'b0;
                    if (frame_start || r_pending) begin
                        r_addr      <= frame_start ? frame_base_addr : r_base;
                        r_frame_cnt <= '0;
                    end else if (w_frame_end) begin
                        r_addr      <= r_base;
                        r_frame_cnt <= '0;
                    end else begin
                        r_addr      <= r_addr + BURST_BYTES;
                        r_frame_cnt <= r_frame_cnt + BURST_F;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign fifo_wr_en   = r_wr_en;
    assign fifo_wr_data = r_wr_data;
    assign burst_req    = (r_state == S_REQ);
    assign burst_addr   = r_addr;
    assign frame_done   = r_frame_done;

`ifdef FIFO_WR_OVERFLOW_CHK_EN
    logic r_ovf;

    // the write is still issued; this only records that data was lost
    always_ff @(posedge fifo_wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (r_wr_en && fifo_full) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf_err = r_ovf;
`else
    logic w_unused_full;

    assign w_unused_full = fifo_full;
    assign ovf_err       = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_ctl.sv
// Scoreboard bench for fifo_wr_ctl: bench acts as memory reader and FIFO,
// a frame-level model predicts addresses, writes and frame_done pulses.
module tb_fifo_wr_ctl;

    localparam int BL = 16;
    localparam int FB = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fifo_wr_en;
    logic [15:0] fifo_wr_data;
    logic        fifo_full;
    logic [9:0]  fifo_wr_cnt;
    logic        frame_start;
    logic [31:0] frame_base_addr;
    logic        burst_req;
    logic [31:0] burst_addr;
    logic        burst_ack;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        frame_done;
    logic        ovf_err;

    fifo_wr_ctl #(
        .FIFO_ALMOSTFULL_DEPTH(1000),
        .BURST_LEN(BL),
        .FRAME_BEATS(FB),
        .DATA_WIDTH(16),
        .ADDR_WIDTH(32)
    ) dut (
        .rst_n(rst_n),
        .fifo_wr_clk(clk),
        .fifo_wr_en(fifo_wr_en),
        .fifo_wr_data(fifo_wr_data),
        .fifo_full(fifo_full),
        .fifo_wr_cnt(fifo_wr_cnt),
        .frame_start(frame_start),
        .frame_base_addr(frame_base_addr),
        .burst_req(burst_req),
        .burst_addr(burst_addr),
        .burst_ack(burst_ack),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .frame_done(frame_done),
        .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        int          cyc;
        bit          done;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          mon_en = 0;
    bit          m_ovf  = 0;
    int          m_done = 0;
    int          n_done = 0;
    logic [31:0] m_base = '0;
    int          m_off  = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

`ifdef FIFO_WR_OVERFLOW_CHK_EN
    always @(posedge clk)
        if (mon_en && fifo_wr_en && fifo_full) m_ovf = 1'b1;
`endif

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (fifo_wr_en) begin
                chk("write_expected", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("wr_data", 64'(fifo_wr_data), 64'(e.data));
                    chk("wr_latency", 64'(cyc), 64'(e.cyc + 1));
                    chk("frame_done_last", 64'(frame_done), 64'(e.done));
                end
            end else begin
                chk("frame_done_idle", 64'(frame_done), 0);
            end
            if (frame_done) n_done++;
            chk("ovf_err", 64'(ovf_err), 64'(m_ovf));
        end
    end

    task automatic run_burst(input int ack_d, input int gap, input int fs_beat,
                             input logic [31:0] fs_base, input bit blocked,
                             input logic [31:0] idle_base, input bit full,
                             input bit block_next, input int n_beats);
        logic [31:0] ea;
        int          n;
        int          d;
        int          g;
        bit          pend;
        exp_t        e;
        pend = 0;
        e.data = '0;
        e.cyc = 0;
        e.done = 0;
        if (blocked) begin
            repeat (6) begin
                @(negedge clk);
                chk("req_while_985", 64'(burst_req), 0);
            end
            if (idle_base != 0) begin
                frame_start = 1;
                frame_base_addr = idle_base;
                m_base = idle_base;
                m_off = 0;
                @(negedge clk);
                frame_start = 0;
                chk("req_after_idle_fs", 64'(burst_req), 0);
            end
            fifo_wr_cnt = 10'd984;
            @(negedge clk);
            chk("req_at_984", 64'(burst_req), 1);
        end else begin
            n = 0;
            while (!burst_req && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("req_timeout", 64'(burst_req), 1);
        end
        ea = m_base + 32'(m_off * 2);
        chk("burst_addr", 64'(burst_addr), 64'(ea));
        fifo_full = full;
        d = (ack_d < 0) ? int'($urandom_range(0, 3)) : ack_d;
        for (int k = 0; k < d; k++) begin
            rd_valid = 1'($urandom_range(0, 1));
            rd_data = 16'($urandom);
            @(negedge clk);
            rd_valid = 0;
            chk("req_held", 64'(burst_req), 1);
            chk("addr_held", 64'(burst_addr), 64'(ea));
        end
        burst_ack = 1;
        @(negedge clk);
        burst_ack = 0;
        chk("req_dropped", 64'(burst_req), 0);
        for (int b = 0; b < n_beats; b++) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            repeat (g) @(negedge clk);
            rd_valid = 1;
            rd_data = 16'($urandom);
            if (b == fs_beat) begin
                frame_start = 1;
                frame_base_addr = fs_base;
                pend = 1;
            end
            e.data = rd_data;
            e.cyc = cyc;
            e.done = 0;
            if (b == BL - 1) begin
                e.done = !pend && (m_off + BL == FB);
                fifo_wr_cnt = block_next ? 10'd985 : 10'($urandom_range(0, 500));
            end
            exp_q.push_back(e);
            @(negedge clk);
            rd_valid = 0;
            frame_start = 0;
        end
        if (n_beats == BL) begin
            if (e.done) m_done++;
            if (pend) begin
                m_base = fs_base;
                m_off = 0;
            end else begin
                m_off += BL;
                if (m_off == FB) m_off = 0;
            end
            rd_valid = 1'($urandom_range(0, 1));
            rd_data = 16'($urandom);
            @(negedge clk);
            rd_valid = 0;
            fifo_full = 0;
        end
    endtask

    task automatic chk_reset_outs();
        chk("rst_wr_en", 64'(fifo_wr_en), 0);
        chk("rst_wr_data", 64'(fifo_wr_data), 0);
        chk("rst_burst_req", 64'(burst_req), 0);
        chk("rst_burst_addr", 64'(burst_addr), 0);
        chk("rst_frame_done", 64'(frame_done), 0);
        chk("rst_ovf_err", 64'(ovf_err), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0;
        fifo_full = 0;
        fifo_wr_cnt = '0;
        frame_start = 0;
        frame_base_addr = '0;
        burst_ack = 0;
        rd_data = '0;
        rd_valid = 0;
        repeat (2) @(negedge clk);
        chk_reset_outs();
        @(posedge clk);
        #2;
        rst_n = 1;
        mon_en = 1;
        repeat (4) begin
            @(negedge clk);
            chk("req_unarmed", 64'(burst_req), 0);
        end
        frame_start = 1;
        frame_base_addr = 32'h1000_0000;
        m_base = 32'h1000_0000;
        m_off = 0;
        @(negedge clk);
        frame_start = 0;

        run_burst(5, 2, -1, '0, 0, '0, 0, 0, BL);
        run_burst(-1, -1, -1, '0, 0, '0, 0, 1, BL);
        run_burst(-1, -1, -1, '0, 1, '0, 1, 0, BL);
        run_burst(-1, -1, -1, '0, 0, '0, 0, 0, BL);
        run_burst(-1, -1, -1, '0, 0, '0, 0, 0, BL);
        run_burst(-1, -1, 7, 32'h2000_0000, 0, '0, 0, 0, BL);
        for (int i = 0; i < 7; i++)
            run_burst(-1, -1, -1, '0, 0, '0, 0, 0, BL);
        run_burst(-1, -1, 15, 32'h3000_0000, 0, '0, 0, 0, BL);
        run_burst(-1, -1, -1, '0, 0, '0, 0, 1, BL);
        run_burst(-1, -1, -1, '0, 1, 32'h4000_0000, 0, 0, BL);
        run_burst(-1, -1, -1, '0, 0, '0, 0, 0, 5);

        @(negedge clk);
        @(posedge clk);
        #2;
        mon_en = 0;
        rst_n = 0;
        exp_q.delete();
        m_ovf = 0;
        @(negedge clk);
        chk_reset_outs();
        @(posedge clk);
        #2;
        rst_n = 1;
        mon_en = 1;
        fifo_wr_cnt = '0;
        repeat (8) begin
            @(negedge clk);
            chk("req_after_reset", 64'(burst_req), 0);
        end
        frame_start = 1;
        frame_base_addr = 32'h5000_0000;
        m_base = 32'h5000_0000;
        m_off = 0;
        @(negedge clk);
        frame_start = 0;
        run_burst(-1, -1, -1, '0, 0, '0, 0, 0, BL);

        repeat (6) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 0);
        chk("frame_done_count", 64'(n_done), 64'(m_done));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
